// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, redirect handling, in-order memory returns into a prefetch FIFO.
// Latency: first request 1 cycle after reset release; rvalid-to-instr_valid is 1 cycle (show-ahead FIFO).
// Backpressure: requests are credit-limited so that FIFO occupancy + in-flight requests never exceed DEPTH.
module fetch_unit #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter logic [WIDTH-1:0]  PC_STEP  = WIDTH'(4)
) (
  input  logic             clk_i,
  input  logic             reset_i,        // asynchronous, active low
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i
);

  localparam int unsigned  CW      = $clog2(DEPTH + 1);
  localparam int unsigned  AW      = $clog2(DEPTH);
  localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);

  logic             running_q;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    discard_q, discard_d;

  // Address queue: remembers the PC of every granted request until its data returns.
  logic [WIDTH-1:0] aq_mem [DEPTH];
  logic [AW-1:0]    aq_wr_q, aq_rd_q;

  // Prefetch FIFO storage: PC and instruction word per entry.
  logic [WIDTH-1:0] fq_pc  [DEPTH];
  logic [WIDTH-1:0] fq_dat [DEPTH];
  logic [AW-1:0]    fq_wr_q, fq_rd_q;

  logic [CW:0] credit_used;
  logic        grant, ret, drop, push, pop;

  // Handshake decode: request credit, accepted grant, legal return, drop/push/pop qualifiers.
  always_comb begin
    credit_used   = {1'b0, occ_q} + {1'b0, inflight_q};
    mem_req_o     = running_q && (credit_used < DEPTH_C);
    mem_addr_o    = fetch_pc_q;
    grant         = mem_req_o & mem_gnt_i;
    // A return with nothing in flight is a protocol violation and is ignored.
    ret           = mem_rvalid_i & (inflight_q != '0);
    drop          = ret & (discard_q != '0);
    // During a redirect the FIFO is flushed, so nothing is written and nothing popped.
    push          = ret & ~drop & ~redirect_i;
    instr_valid_o = (occ_q != '0);
    pop           = instr_valid_o & instr_ready_i & ~redirect_i;
    instr_o       = instr_valid_o ? fq_dat[fq_rd_q] : '0;
    instr_pc_o    = instr_valid_o ? fq_pc[fq_rd_q]  : '0;
  end

  // Next-state for PC and counters; redirect overrides everything else.
  always_comb begin
    inflight_d = inflight_q + CW'(grant) - CW'(ret);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      // Everything still outstanding after this edge (incl. a same-cycle grant) is old-path.
      discard_d  = inflight_d;
      occ_d      = '0;
    end else begin
      fetch_pc_d = grant ? fetch_pc_q + PC_STEP : fetch_pc_q;
      discard_d  = discard_q - CW'(drop);
      occ_d      = occ_q + CW'(push) - CW'(pop);
    end
  end

  // Control state: run flag, PC, counters and queue pointers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      running_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      occ_q      <= '0;
      discard_q  <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
    end else begin
      running_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      discard_q  <= discard_d;
      if (grant) aq_wr_q <= aq_wr_q + AW'(1);
      if (ret)   aq_rd_q <= aq_rd_q + AW'(1);
      if (redirect_i) begin
        fq_wr_q <= '0;
        fq_rd_q <= '0;
      end else begin
        if (push) fq_wr_q <= fq_wr_q + AW'(1);
        if (pop)  fq_rd_q <= fq_rd_q + AW'(1);
      end
    end
  end

  // Queue storage; contents are qualified by the counters so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (grant) aq_mem[aq_wr_q] <= fetch_pc_q;
    if (push) begin
      fq_pc[fq_wr_q]  <= aq_mem[aq_rd_q];
      fq_dat[fq_wr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: randomized memory/consumer/redirect stimulus against a transaction-level model.
// Latency: n/a (bench).
// Backpressure: consumer ready and memory grant are randomized per phase.
module tb_fetch_unit;

  localparam int          D    = 4;
  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] STEP = 32'h4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_gnt, mem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .DEPTH(D), .RESET_PC(RPC), .PC_STEP(STEP)) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready)
  );

  // Outstanding memory request: address, whether it still belongs to the live path, earliest return cycle.
  typedef struct { logic [31:0] addr; bit live; int due; } pend_t;
  // Instruction the consumer is expected to receive.
  typedef struct { logic [31:0] pc; logic [31:0] dat; } ins_t;

  pend_t pend[$];
  ins_t  sb[$];
  ins_t  mon_e;

  int checks = 0, errors = 0, cyc = 0, pop_cnt = 0, grant_cnt = 0, p0 = 0;
  bit running_m = 1'b0;
  logic [31:0] exp_pc = RPC;
  int p_gnt = 100, p_rv = 100, max_lat = 0, p_ready = 100, p_redir = 0, p_bogus = 0;
  bit force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check DUT state against the model, drive new inputs, then apply the coming edge to the model.
  task automatic step();
    bit    granted;
    pend_t e;
    @(negedge clk);
    cyc++;
    chk("mem_req",     {31'b0, mem_req},     {31'b0, running_m && (sb.size() + pend.size() < D)});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
    chk("mem_addr",    mem_addr, exp_pc);

    mem_gnt     = ($urandom_range(0, 99) < p_gnt);
    instr_ready = ($urandom_range(0, 99) < p_ready);
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    if (pend.size() != 0) begin
      if (pend[0].due <= cyc && $urandom_range(0, 99) < p_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend[0].addr);
      end
    end else if ($urandom_range(0, 99) < p_bogus) begin
      mem_rvalid = 1'b1;
    end
    redirect    = force_redir || ($urandom_range(0, 99) < p_redir);
    redirect_pc = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
    force_redir = 1'b0;

    granted = mem_req && mem_gnt;
    if (mem_rvalid && pend.size() != 0) begin
      e = pend.pop_front();
      if (e.live) sb.push_back('{pc: e.addr, dat: mem_word(e.addr)});
    end
    if (granted) begin
      grant_cnt++;
      pend.push_back('{addr: exp_pc, live: 1'b1, due: cyc + 1 + $urandom_range(0, max_lat)});
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].live = 1'b0;
      sb.delete();
      exp_pc = redirect_pc;
    end else if (granted) begin
      exp_pc = exp_pc + STEP;
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; memory model is cleared with it.
  task automatic do_reset();
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    mem_rdata = '0; redirect_pc = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req",     {31'b0, mem_req},     32'h0);
    chk("rst_mem_addr",    mem_addr,             RPC);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr",       instr,                32'h0);
    chk("rst_instr_pc",    instr_pc,             32'h0);
    pend.delete();
    sb.delete();
    running_m = 1'b0;
    exp_pc    = RPC;
    grant_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst_hold_req", {31'b0, mem_req}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_req", {31'b0, mem_req}, 32'h0);
    // The next edge sets the run flag.
    running_m = 1'b1;
  endtask

  // Monitor: every accepted head instruction must match the oldest expected one.
  always @(negedge clk) begin
    #1;
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h data %h, expected none", instr_pc, instr);
      end else begin
        mon_e = sb.pop_front();
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("instr",    instr,    mon_e.dat);
        pop_cnt++;
      end
    end
  end

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    mem_rdata = '0; redirect_pc = '0;
    do_reset();

    // Streaming: full grant, 1-cycle return, always ready -> one instruction per cycle.
    p_gnt = 100; p_rv = 100; max_lat = 0; p_ready = 100; p_redir = 0; p_bogus = 0;
    repeat (30) step();
    p0 = pop_cnt;
    repeat (20) step();
    chk("stream_rate", pop_cnt - p0, 32'd20);

    // Redirect in steady state: coincides with grant, return and pop.
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    step();
    repeat (12) step();

    // Address wrap through the top of the address space.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    step();
    repeat (12) step();

    // Backpressure: exactly DEPTH grants, then stall with head at RESET_PC.
    do_reset();
    p_ready = 0;
    repeat (12) step();
    chk("bp_grants",      grant_cnt, 32'd4);
    chk("bp_req",         {31'b0, mem_req},     32'h0);
    chk("bp_instr_valid", {31'b0, instr_valid}, 32'h1);
    chk("bp_head_pc",     instr_pc, RPC);
    p_ready = 100;
    repeat (12) step();

    // Redirect with several requests in flight (longer return latency).
    do_reset();
    max_lat = 2;
    repeat (8) step();
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    repeat (15) step();

    // Mid-operation reset with a full FIFO and requests outstanding.
    p_ready = 0; max_lat = 4;
    repeat (6) step();
    do_reset();
    p_ready = 100; max_lat = 0;
    repeat (6) step();

    // Randomized phases with occasional stray returns and resets.
    for (int blk = 0; blk < 30; blk++) begin
      p_gnt   = $urandom_range(20, 100);
      p_rv    = $urandom_range(30, 100);
      max_lat = $urandom_range(0, 4);
      p_ready = $urandom_range(0, 100);
      p_redir = $urandom_range(0, 8);
      p_bogus = 5;
      if (blk % 10 == 9) do_reset();
      if (blk % 7 == 3) begin
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFF4;
      end
      repeat (100) step();
    end

    // Drain so any residual expectation mismatch surfaces.
    p_gnt = 0; p_rv = 100; p_ready = 100; p_redir = 0; p_bogus = 0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the fixed 32-bit `pc` register.
- Generates sequential fetch addresses and accepts branch/jump redirects.
- Issues requests to an instruction memory that has grant and in-order return.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO, which feeds the decode stage through a valid/ready handshake.

Parameters:
- WIDTH, 32, address and instruction width.
- DEPTH, 4, prefetch FIFO entries and the maximum number of in-flight requests; a power of 2, at least 2.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, fetch address increment.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mem_req  out  1  fetch request valid.
- mem_addr  out  WIDTH  fetch address (current fetch PC).
- mem_gnt  in  1  request accepted this cycle; meaningful only while mem_req=1.
- mem_rvalid  in  1  return data valid; returns are in order, one per granted request, at least 1 cycle after grant.
- mem_rdata  in  WIDTH  returned instruction.
- redirect  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  WIDTH  new fetch PC.
- instr_valid  out  1  FIFO head valid.
- instr  out  WIDTH  FIFO head instruction.
- instr_pc  out  WIDTH  address of the FIFO head instruction.
- instr_ready  in  1  consumer accepts the head.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, mem_req=0.
  - instr_valid=0, instr=0, instr_pc=0.
  - occupancy, inflight and discard counters all 0; running flag=0.
- running is set on the first clk edge after reset deasserts, so the first mem_req=1 appears one cycle after release.
- Issue rule:
  - mem_req = running & (occupancy + inflight < DEPTH).
  - mem_addr = fetch_pc, driven from a register.
- Accepted request (mem_req & mem_gnt):
  - fetch_pc += PC_STEP, modulo 2^WIDTH.
  - inflight += 1.
  - The issued address is pushed into a DEPTH-entry address queue.
- Return (mem_rvalid):
  - Pop the address queue; inflight -= 1.
  - If discard>0: drop the data and decrement discard.
  - Otherwise: push {address, mem_rdata} into the FIFO.
  - mem_rvalid with inflight=0 is a protocol violation; ignore it and leave state unchanged.
- FIFO:
  - Show-ahead: data pushed at edge t is visible on instr_valid/instr/instr_pc after edge t (one-cycle rvalid-to-output latency).
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop keeps occupancy unchanged, even when full.
  - No overflow is possible, by the credit rule.
- Redirect (highest priority):
  - At the edge: fetch_pc <= redirect_pc.
  - FIFO flushed (occupancy=0); instr_valid=0 from the next cycle.
  - discard <= inflight + (mem_req&mem_gnt) − mem_rvalid. Any request granted in the redirect cycle carries the old address and is discarded.
  - A pop in the same cycle as redirect is ignored (flush wins).
  - mem_req is not masked in the redirect cycle.
  - The new-path request may issue in the next cycle while discards are still pending.
  - Back-to-back redirects: the later one wins; discard is recomputed each time.
- Ordering: the consumer observes instr_pc values of one path strictly incrementing by PC_STEP; no instruction fetched before a redirect is delivered after it.
- Invariant: occupancy + inflight ≤ DEPTH at all times.
- Reset mid-operation: all state is cleared immediately. The memory model is reset in the same cycle, so there are no stale returns.

Test Plan:
- Streaming, DEPTH=4, RESET_PC=0, gnt=1, rvalid one cycle after grant, instr_ready=1 → mem_addr 0,4,8,C,…; instr_valid steady at 1 after fill; instr_pc 0,4,8,… at one instruction per cycle.
- Backpressure: instr_ready=0 → exactly 4 grants (0,4,8,C) then mem_req=0 with the FIFO full (head instr_pc=0); raise instr_ready → pops 0,4,8,C, then mem_req resumes at 0x10.
- Redirect to 0x100 with inflight=2 → the next 2 rvalids are dropped; instr_valid=0 until the 0x100 data returns; mem_addr=0x100 in the cycle after redirect; instr_pc sequence 0x100,0x104.
- Simultaneous redirect + gnt + rvalid + pop, with inflight=1 before → discard=1; FIFO empty next cycle; the granted old-path address is not delivered; first delivered instr_pc=redirect_pc.
- Wrap: RESET_PC=0xFFFFFFF8 → mem_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; instr_pc follows the same sequence.
- Reset pulse with a full FIFO and inflight=2 → outputs zero in the same cycle, mem_req=0; after release, the first mem_req is at RESET_PC one cycle later.
